// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared constants and payload types for the instruction fetch unit.
// Holds the reset PC, the NOP encoding and the decode-side entry layout.
package ysyx_22041412_ifu_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // One decode-side slot: PC, instruction word and misalignment flag
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041412_ifu_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Head is read straight from storage, so a push is visible the next cycle.
module ysyx_22041412_ifu_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: owns the PC, issues credit-limited fetches and
// buffers in-order responses for decode; EX redirects squash wrong-path words.
module ysyx_22041412_ifu
    import ysyx_22041412_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_misalign
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] kill_cnt_q;
    logic             halt_q;

    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W-1:0] pcq_cnt;
    logic [XLEN-1:0]  pcq_head;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_wdata;

    logic [SUM_W-1:0] credit_used;
    logic             can_issue;
    logic             pc_mis;
    logic             id_pop;
    logic             req_fire;
    logic             rsp_live;
    logic             mis_push;
    logic             fifo_push;

    assign id_valid = (fifo_cnt != '0);
    assign id_pop   = id_valid && id_ready;

    // A head leaving this cycle frees its credit, which sustains one instr per cycle
    assign credit_used = SUM_W'(fifo_cnt) + SUM_W'(outstanding_q) - SUM_W'(id_pop);
    assign can_issue   = credit_used < SUM_W'(DEPTH);
    assign pc_mis      = pc_misaligned(pc_q[1:0]);

    assign imem_req_valid = !rst && can_issue && !redirect_valid && !halt_q && !pc_mis;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Misaligned PC bypasses memory once older fetches have drained, keeping order
    assign mis_push = can_issue && !redirect_valid && !halt_q && pc_mis && (outstanding_q == '0);
    assign rsp_live = imem_rsp_valid && !redirect_valid && (kill_cnt_q == '0);

    assign fifo_push = rsp_live || mis_push;

    always_comb begin
        fifo_wdata = '{pc: pcq_head, instr: imem_rsp_data, misalign: 1'b0};
        if (mis_push) begin
            fifo_wdata = '{pc: pc_q, instr: NOP_INSTR, misalign: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            halt_q        <= 1'b0;
        end else if (redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old path
            pc_q          <= redirect_pc;
            outstanding_q <= outstanding_q - CNT_W'(imem_rsp_valid);
            kill_cnt_q    <= outstanding_q - CNT_W'(imem_rsp_valid);
            halt_q        <= 1'b0;
        end else begin
            if (req_fire) begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (mis_push) begin
                halt_q <= 1'b1;
            end
            outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (imem_rsp_valid && (kill_cnt_q != '0)) begin
                kill_cnt_q <= kill_cnt_q - CNT_W'(1);
            end
        end
    end

    ysyx_22041412_ifu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (id_pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    ysyx_22041412_ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_live),
        .head      (pcq_head),
        .count     (pcq_cnt)
    );

    assign id_pc       = fifo_head.pc;
    assign id_instr    = fifo_head.instr;
    assign id_misalign = fifo_head.misalign;

    // Every accepted response must have a recorded fetch PC
    rsp_has_pc: assert property (@(posedge clk) disable iff (rst) rsp_live |-> (pcq_cnt != '0));

endmodule
